// File: rtl/data_mem_resp.sv
// Data memory responder: one-outstanding load/store FSM over a word array.
// Define DMEM_MISALIGN_CHK_EN to reject misaligned half/word accesses.
module data_mem_resp #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          acc;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [31:0]   ext;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [1:0]    lat_size;
  logic [1:0]    lat_lane;
  logic          lat_uns;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign acc       = req_valid && req_ready;
  assign idx       = AW'({26'd0, req_addr[7:2]} % 32'(DEPTH));

  always_comb begin
    err = (req_size == 2'b11);
`ifdef DMEM_MISALIGN_CHK_EN
    if (req_size == 2'b01 && req_addr[0])
      err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      err = 1'b1;
`endif
  end

  // Without the check, low address bits below the access size are ignored
  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    unique case (req_size)
      2'b00: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest && acc && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign bsel = rd_word[{lat_lane, 3'b000} +: 8];
  assign hsel = lat_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ext = rd_word;
    unique case (lat_size)
      2'b00:   ext = {{24{!lat_uns && bsel[7]}}, bsel};
      2'b01:   ext = {{16{!lat_uns && hsel[15]}}, hsel};
      default: ext = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_word   <= '0;
      lat_size  <= 2'b00;
      lat_lane  <= 2'b00;
      lat_uns   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            lat_size  <= req_size;
            lat_lane  <= req_addr[1:0];
            lat_uns   <= req_unsigned;
            rsp_rdata <= '0;
            rsp_err   <= err;
            if (err || req_we) begin
              state <= RSP;
            end else begin
              state   <= RD;
              rd_word <= mem[idx];
            end
          end
        end
        RD: begin
          rsp_rdata <= ext;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
